ex_muldiv: RTL

Multi-cycle RV32M/RV64M multiply/divide unit that sits beside the single-cycle execute ALU. It accepts one operation per request and holds the pipeline through a stall request while it iterates. It returns the result with a register-write destination in the same form the execute stage hands to memory access. Width and per-cycle throughput are parametrised, and special division cases complete early.

---
 rtl/ex_muldiv.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit beside the execute ALU.
// It works on operand magnitudes and applies the sign correction when the result is written.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            reg_we_i,
  output logic            stall_req_o,
  output logic            done_o,
  output logic [4:0]      reg_waddr_o,
  output logic            reg_we_o,
  output logic [XLEN-1:0] reg_wdata_o
);

  localparam int ITER = XLEN / STEPS;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        opCap_q, opCap_d;
  logic              neg1_q, neg1_d, neg2_q, neg2_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   opB_q, opB_d;
  logic [4:0]        waddrCap_q, waddrCap_d;
  logic              weCap_q, weCap_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic              op1Signed, op2Signed, neg1, neg2;
  logic [XLEN-1:0]   abs1, abs2;
  logic              divByZero, divOverflow;
  logic [XLEN-1:0]   earlyResult;

  logic [2*XLEN-1:0] mulAcc, prodFix;
  logic [XLEN:0]     mulSum, divShift, divDiff;
  logic [XLEN-1:0]   divQuo, divRem, quoFix, remFix, calcResult;

  always_comb begin
    op1Signed = 1'b0;
    op2Signed = 1'b0;
    case (op_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        op1Signed = 1'b1;
        op2Signed = 1'b1;
      end
      3'b010:  op1Signed = 1'b1;
      default: ;
    endcase
  end

  assign neg1 = op1Signed & op1_i[XLEN-1];
  assign neg2 = op2Signed & op2_i[XLEN-1];
  assign abs1 = neg1 ? -op1_i : op1_i;
  assign abs2 = neg2 ? -op2_i : op2_i;

  assign divByZero   = op_i[2] & (op2_i == '0);
  assign divOverflow = op_i[2] & ~op_i[0] & (op1_i == MOST_NEG) & (op2_i == '1);

  always_comb begin
    earlyResult = '0;
    if (divByZero)
      earlyResult = op_i[1] ? op1_i : '1;
    else if (divOverflow)
      earlyResult = op_i[1] ? '0 : op1_i;
  end

  // One clock of iteration: STEPS shift-add or restoring-divide steps, unrolled.
  always_comb begin
    mulAcc   = acc_q;
    mulSum   = '0;
    divQuo   = acc_q[XLEN-1:0];
    divRem   = rem_q;
    divShift = '0;
    divDiff  = '0;
    for (int s = 0; s < STEPS; s++) begin
      if (opCap_q[2]) begin
        divShift = {divRem, divQuo[XLEN-1]};
        divDiff  = divShift - {1'b0, opB_q};
        divQuo   = {divQuo[XLEN-2:0], ~divDiff[XLEN]};
        divRem   = divDiff[XLEN] ? divShift[XLEN-1:0] : divDiff[XLEN-1:0];
      end else begin
        mulSum = {1'b0, mulAcc[2*XLEN-1:XLEN]} + (mulAcc[0] ? {1'b0, opB_q} : '0);
        mulAcc = {mulSum, mulAcc[XLEN-1:1]};
      end
    end
  end

  assign prodFix = (neg1_q ^ neg2_q) ? -mulAcc : mulAcc;
  assign quoFix  = (neg1_q ^ neg2_q) ? -divQuo : divQuo;
  assign remFix  = neg1_q ? -divRem : divRem;

  always_comb begin
    case (opCap_q)
      3'b000:                 calcResult = prodFix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calcResult = prodFix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calcResult = quoFix;
      default:                calcResult = remFix;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    opCap_d    = opCap_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    opB_d      = opB_q;
    waddrCap_d = waddrCap_q;
    weCap_d    = weCap_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          opCap_d    = op_i;
          neg1_d     = neg1;
          neg2_d     = neg2;
          waddrCap_d = reg_waddr_i;
          weCap_d    = reg_we_i;
          count_d    = CW'(ITER);
          rem_d      = '0;
          acc_d      = {{XLEN{1'b0}}, (op_i[2] ? abs1 : abs2)};
          opB_d      = op_i[2] ? abs2 : abs1;
          if (divByZero || divOverflow) begin
            state_d = DONE;
            wdata_d = earlyResult;
            waddr_d = reg_waddr_i;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d   = opCap_q[2] ? {{XLEN{1'b0}}, divQuo} : mulAcc;
        rem_d   = divRem;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = DONE;
          wdata_d = calcResult;
          waddr_d = waddrCap_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // A cancelled operation must leave the visible result untouched.
    if (flush_i) begin
      state_d = IDLE;
      count_d = '0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      opCap_q    <= '0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      acc_q      <= '0;
      rem_q      <= '0;
      opB_q      <= '0;
      waddrCap_q <= '0;
      weCap_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      opCap_q    <= opCap_d;
      neg1_q     <= neg1_d;
      neg2_q     <= neg2_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      opB_q      <= opB_d;
      waddrCap_q <= waddrCap_d;
      weCap_q    <= weCap_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign stall_req_o = ((state_q == IDLE) && start_i && !flush_i) || (state_q == CALC);
  assign done_o      = (state_q == DONE) && !flush_i;
  assign reg_we_o    = done_o && weCap_q;
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;

endmodule
